board_count_sequencer: RTL and testbench

- Sequences the single-port board memory (ROM module, DATA_WIDTH-wide words, negedge-registered read/write) to fill in every cell's neighbour-mine count after mine placement.
- Walks the board in raster order. For each cell it reads the centre and its in-bounds neighbours, counts mine bits, and writes the count back into the cell.
- While idle, it passes the game-logic port straight through to the memory. While busy, it owns the memory exclusively.

---
 rtl/board_count_sequencer.sv | 140 ++++++++++++++
 tb/tb_board_count_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/board_count_sequencer.sv
// board_count_sequencer: fills every board cell's neighbour-mine count by raster-walking the single-port board memory.
module board_count_sequencer #(
    parameter int ROWS          = 16,
    parameter int COLS          = 16,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 32,
    parameter int MINE_BIT      = 0,
    parameter int COUNT_LSB     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic [ADDRESS_WIDTH-1:0] ext_addr,
    input  logic                     ext_wen,
    input  logic [DATA_WIDTH-1:0]    ext_wdata,
    output logic [DATA_WIDTH-1:0]    ext_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_wen,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {IDLE, RD, NBR, ACC, WR} state_t;

    state_t                   state;
    logic [RW-1:0]            row;
    logic [CW-1:0]            col;
    logic [3:0]               nidx;
    logic [3:0]               acc;
    logic [DATA_WIDTH-1:0]    centre_word;
    logic [ADDRESS_WIDTH-1:0] seq_addr;
    logic                     seq_wen;
    logic [DATA_WIDTH-1:0]    seq_wdata;
    logic [ADDRESS_WIDTH-1:0] centre_addr;
    logic [ADDRESS_WIDTH-1:0] nlist [8];
    logic [3:0]               ncnt;
    logic [DATA_WIDTH-1:0]    wr_word;
    logic                     last_cell;
    logic                     own;
    int                       r;
    int                       c;

    assign centre_addr = ADDRESS_WIDTH'(int'(row) * COLS + int'(col));
    assign last_cell   = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

    // Compact list of in-bounds neighbours in NW,N,NE,W,E,SW,S,SE order.
    always_comb begin
        ncnt = '0;
        r = 0;
        c = 0;
        for (int i = 0; i < 8; i++) nlist[i] = '0;
        for (int i = 0; i < 8; i++) begin
            r = int'(row) + ((i < 3) ? -1 : (i < 5) ? 0 : 1);
            c = int'(col) + ((i == 0 || i == 3 || i == 5) ? -1 : (i == 1 || i == 6) ? 0 : 1);
            if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
                nlist[ncnt[2:0]] = ADDRESS_WIDTH'(r * COLS + c);
                ncnt = ncnt + 4'd1;
            end
        end
    end

    always_comb begin
        wr_word = centre_word;
        wr_word[COUNT_LSB +: 4] = acc;
    end

    // The final write is still in flight during the first IDLE cycle, so seq_wen keeps the port.
    assign own       = (state != IDLE) || seq_wen;
    assign mem_addr  = own ? seq_addr  : ext_addr;
    assign mem_wen   = own ? seq_wen   : ext_wen;
    assign mem_wdata = own ? seq_wdata : ext_wdata;
    assign ext_rdata = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            row         <= '0;
            col         <= '0;
            nidx        <= '0;
            acc         <= '0;
            centre_word <= '0;
            seq_addr    <= '0;
            seq_wen     <= 1'b0;
            seq_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    seq_wen <= 1'b0;
                    if (start) begin
                        row   <= '0;
                        col   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RD;
                    end
                end
                RD: begin
                    seq_addr <= centre_addr;
                    seq_wen  <= 1'b0;
                    nidx     <= '0;
                    state    <= NBR;
                end
                NBR: begin
                    if (nidx == 4'd0) centre_word <= mem_rdata;
                    else acc <= acc + 4'(mem_rdata[MINE_BIT]);
                    seq_addr <= nlist[nidx[2:0]];
                    nidx     <= nidx + 4'd1;
                    if (nidx + 4'd1 >= ncnt) state <= ACC;
                end
                ACC: begin
                    if (ncnt != 4'd0) acc <= acc + 4'(mem_rdata[MINE_BIT]);
                    state <= WR;
                end
                WR: begin
                    seq_wen   <= 1'b1;
                    seq_addr  <= centre_addr;
                    seq_wdata <= wr_word;
                    acc       <= '0;
                    if (last_cell) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        col   <= (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
                        row   <= (col == CW'(COLS - 1)) ? row + RW'(1) : row;
                        state <= RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_count_sequencer.sv
// tb_board_count_sequencer: directed checks of the count pass on a 4x4 board with a negedge-registered memory model.
module tb_board_count_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] ext_addr = '0;
    logic        ext_wen = 1'b0;
    logic [31:0] ext_wdata = '0;
    logic [31:0] ext_rdata;
    logic [11:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] dout;
    logic [31:0] mem [16];
    logic        load = 1'b0;
    int          pat = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    board_count_sequencer #(.ROWS(4), .COLS(4), .ADDRESS_WIDTH(12), .DATA_WIDTH(32),
                            .MINE_BIT(0), .COUNT_LSB(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ext_addr(ext_addr), .ext_wen(ext_wen), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(dout)
    );

    function automatic logic [31:0] pat_word(input int k, input int i);
        return (k == 0) ? ((i == 5) ? 32'h1 : 32'h0) : (k == 1) ? 32'h21 : 32'h1E;
    endfunction

    function automatic logic [31:0] exp_word(input int k, input int i);
        if (k == 0) return (i == 5) ? 32'h1 : (i <= 2 || i == 4 || i == 6 || (i >= 8 && i <= 10)) ? 32'h2 : 32'h0;
        if (k == 1) return (i == 0 || i == 3 || i == 12 || i == 15) ? 32'h27 :
                           (i == 5 || i == 6 || i == 9 || i == 10) ? 32'h31 : 32'h2B;
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        if (load) for (int i = 0; i < 16; i++) mem[i] <= pat_word(pat, i);
        else if (mem_wen) mem[mem_addr[3:0]] <= mem_wdata;
        dout <= mem[mem_addr[3:0]];
    end

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input int k);
        pat = k;
        load = 1'b1;
        cyc;
        load = 1'b0;
    endtask

    task automatic run_pass(input bit intr, output int len, output logic d_end, output logic d_next);
        start = 1'b1;
        cyc;
        start = 1'b0;
        len = 0;
        while (busy && len < 1000) begin
            len++;
            if (intr) begin
                start = (len == 10);
                ext_wen = 1'b1;
                ext_addr = 12'd3;
                ext_wdata = 32'hFF;
            end
            cyc;
        end
        start = 1'b0;
        ext_wen = 1'b0;
        d_end = done;
        cyc;
        d_next = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ext_wen = 1'b1;
        ext_addr = 12'd7;
        repeat (2) cyc;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: busy=%b done=%b want 0 0", busy, done);
        end
        vectors++;
        if (mem_wen !== 1'b1 || mem_addr !== 12'd7) begin
            miscompares++;
            $display("FAIL reset_passthru: wen=%b addr=%0d want 1 7", mem_wen, mem_addr);
        end
        ext_wen = 1'b0;
        ext_addr = 12'd9;
        #1;
        vectors++;
        if (mem_wen !== 1'b0 || mem_addr !== 12'd9) begin
            miscompares++;
            $display("FAIL reset_follow: wen=%b addr=%0d want 0 9", mem_wen, mem_addr);
        end
        rst_n = 1'b1;
        cyc;
    endtask

    task automatic test_pattern(input int k, input bit intr);
        int len;
        logic d_end, d_next;
        preload(k);
        run_pass(intr, len, d_end, d_next);
        vectors++;
        if (len !== 132) begin
            miscompares++;
            $display("FAIL pass_len_p%0d: got %0d want 132", k, len);
        end
        vectors++;
        if (d_end !== 1'b1 || d_next !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_p%0d: got %b%b want 10", k, d_end, d_next);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (mem[i] !== exp_word(k, i)) begin
                miscompares++;
                $display("FAIL cell_p%0d[%0d]: got %h want %h", k, i, mem[i], exp_word(k, i));
            end
        end
    endtask

    task automatic test_busy_isolation;
        test_pattern(0, 1'b1);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_restart: busy=%b want 0", busy);
        end
        ext_wen = 1'b1;
        ext_addr = 12'd3;
        ext_wdata = 32'hFF;
        cyc;
        ext_wen = 1'b0;
        cyc;
        vectors++;
        if (ext_rdata !== 32'hFF || mem[3] !== 32'hFF) begin
            miscompares++;
            $display("FAIL ext_write_after: rdata=%h mem3=%h want ff ff", ext_rdata, mem[3]);
        end
    endtask

    task automatic test_reset_mid_pass;
        preload(0);
        start = 1'b1;
        cyc;
        start = 1'b0;
        repeat (49) cyc;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_wen !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: busy=%b done=%b wen=%b want 0 0 0", busy, done, mem_wen);
        end
        repeat (2) cyc;
        rst_n = 1'b1;
        cyc;
        pat = 0;
        begin
            int len;
            logic d_end, d_next;
            run_pass(1'b0, len, d_end, d_next);
            vectors++;
            if (len !== 132 || d_end !== 1'b1) begin
                miscompares++;
                $display("FAIL rerun_len: got %0d done=%b want 132 1", len, d_end);
            end
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (mem[i] !== exp_word(0, i)) begin
                miscompares++;
                $display("FAIL rerun_cell[%0d]: got %h want %h", i, mem[i], exp_word(0, i));
            end
        end
    endtask

    initial begin
        test_reset;
        test_pattern(0, 1'b0);
        test_pattern(1, 1'b0);
        test_pattern(2, 1'b0);
        test_busy_isolation;
        test_reset_mid_pass;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
